// File: rtl/spare_allocation_controller_if.sv
// Handshake and result bundle between the BIRA spare-allocation sequencer and its driver.
// The slave side is the controller; the master side is the requester/analyzer model.
interface spare_allocation_controller_if #(
   parameter int PCAM  = 8,
   parameter int NPCAM = 30
);
   logic             start;
   logic [PCAM-1:0]  pivot_valid;
   logic [NPCAM-1:0] nonpivot_valid;
   logic [NPCAM-1:0] nonpivot_cover_result;
   logic [PCAM-1:0]  dsss;
   logic [3:0]       rlss;
   logic             busy;
   logic             done;
   logic             repairable;
   logic [PCAM-1:0]  sol_dsss;
   logic [3:0]       sol_rlss;
   logic [4:0]       cand_cnt;

   modport master (
      output start, pivot_valid, nonpivot_valid, nonpivot_cover_result,
      input  dsss, rlss, busy, done, repairable, sol_dsss, sol_rlss, cand_cnt
   );

   modport slave (
      input  start, pivot_valid, nonpivot_valid, nonpivot_cover_result,
      output dsss, rlss, busy, done, repairable, sol_dsss, sol_rlss, cand_cnt
   );
endinterface

// File: rtl/spare_allocation_controller.sv
// Sequencer for the spare allocation analyzer: walks row/column spare assignments in
// ascending order and stops at the first one whose cover vector hits every valid non-pivot fault.
module spare_allocation_controller #(
   parameter int PCAM  = 8,
   parameter int NPCAM = 30,
   parameter int RS    = 2,
   parameter int CS    = 2
) (
   input  logic clk,
   input  logic rst,
   spare_allocation_controller_if.slave bus
);

   typedef enum logic [2:0] {IDLE, CHECK, DRIVE, CAPTURE, DONE} state_t;

   state_t           state, state_nxt;
   logic [PCAM-1:0]  pv;
   logic [NPCAM-1:0] nv;
   logic [3:0]       npiv;
   logic [3:0]       rlss_pc;
   logic             over;
   logic             legal;
   logic             covered;
   logic             last_code;

   function automatic logic [3:0] pop_pivots(input logic [PCAM-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < PCAM; i++) c = c + 4'(v[i]);
      return c;
   endfunction

   function automatic logic [3:0] pop_slots(input logic [3:0] v);
      return 4'(v[0]) + 4'(v[1]) + 4'(v[2]) + 4'(v[3]);
   endfunction

   assign npiv      = pop_pivots(pv);
   assign rlss_pc   = pop_slots(bus.rlss);
   assign over      = npiv > 4'd4;
   assign last_code = bus.rlss == 4'hF;
   // Slots at or above npiv must be unused; rows within RS, remaining pivots within CS.
   assign legal     = ((bus.rlss & (4'hF << npiv)) == 4'd0) &&
                      (rlss_pc <= 4'(RS)) &&
                      (npiv <= rlss_pc + 4'(CS));
   assign covered   = &(bus.nonpivot_cover_result | ~nv);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CHECK;
         CHECK:   state_nxt = over ? DONE : DRIVE;
         DRIVE:   if (legal)          state_nxt = CAPTURE;
                  else if (last_code) state_nxt = DONE;
         CAPTURE: if (covered || last_code) state_nxt = DONE;
                  else                      state_nxt = DRIVE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == CHECK) || (state == DRIVE) || (state == CAPTURE);
      bus.done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pv             <= '0;
         nv             <= '0;
         bus.dsss       <= '0;
         bus.rlss       <= 4'd0;
         bus.repairable <= 1'b0;
         bus.sol_dsss   <= '0;
         bus.sol_rlss   <= 4'd0;
         bus.cand_cnt   <= 5'd0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               pv             <= bus.pivot_valid;
               nv             <= bus.nonpivot_valid;
               bus.rlss       <= 4'd0;
               bus.repairable <= 1'b0;
               bus.sol_dsss   <= '0;
               bus.sol_rlss   <= 4'd0;
               bus.cand_cnt   <= 5'd0;
            end
            CHECK: if (!over) begin
               bus.dsss <= pv;
               bus.rlss <= 4'd0;
            end
            DRIVE: if (!legal && !last_code) bus.rlss <= bus.rlss + 4'd1;
            CAPTURE: begin
               bus.cand_cnt <= bus.cand_cnt + 5'd1;
               if (covered) begin
                  bus.repairable <= 1'b1;
                  bus.sol_rlss   <= bus.rlss;
                  bus.sol_dsss   <= bus.dsss;
               end else if (!last_code) begin
                  bus.rlss <= bus.rlss + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spare_allocation_controller.sv
// Directed bench for spare_allocation_controller: vector table of complete runs plus
// hand-written reset, abort and ignored-start sequences, with a registered analyzer model.
module tb_spare_allocation_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   spare_allocation_controller_if #(.PCAM(8), .NPCAM(30)) bus ();

   spare_allocation_controller #(.PCAM(8), .NPCAM(30), .RS(2), .CS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Analyzer model: cover for the rlss seen at an edge appears in the following cycle.
   logic        cov_en   = 1'b0;
   logic [3:0]  cov_code = 4'd0;
   logic [29:0] cov_hit  = '0;
   always @(posedge clk)
      bus.nonpivot_cover_result <= (!cov_en || bus.rlss == cov_code) ? cov_hit : 30'h0;

   typedef struct {
      logic [7:0]  pv;
      logic [29:0] nv;
      logic        cen;
      logic [3:0]  ccode;
      logic [29:0] chit;
      logic        rep;
      logic [3:0]  srlss;
      logic [7:0]  sdsss;
      logic [4:0]  cnt;
      int          dcyc;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input bit pester);
      int cyc;
      @(negedge clk);
      bus.pivot_valid    = v.pv;
      bus.nonpivot_valid = v.nv;
      cov_en             = v.cen;
      cov_code           = v.ccode;
      cov_hit            = v.chit;
      bus.start          = 1'b1;
      @(negedge clk);
      bus.start          = 1'b0;
      bus.pivot_valid    = 8'hFF;
      bus.nonpivot_valid = 30'h0;
      cyc = 1;
      chk("busy_cycle1", 32'(bus.busy), 32'd1);
      while (!bus.done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (pester && cyc == 3) bus.start = 1'b1;
         if (pester && cyc == 4) bus.start = 1'b0;
      end
      chk("done_cycle", 32'(cyc), 32'(v.dcyc));
      chk("repairable", 32'(bus.repairable), 32'(v.rep));
      chk("sol_rlss", 32'(bus.sol_rlss), 32'(v.srlss));
      chk("sol_dsss", 32'(bus.sol_dsss), 32'(v.sdsss));
      chk("cand_cnt", 32'(bus.cand_cnt), 32'(v.cnt));
      if (pester) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("done_pulse_len", 32'(bus.done), 32'd0);
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      chk("cnt_held", 32'(bus.cand_cnt), 32'(v.cnt));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dsss"}, 32'(bus.dsss), 32'd0);
      chk({tag, "_rlss"}, 32'(bus.rlss), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_rep"}, 32'(bus.repairable), 32'd0);
      chk({tag, "_sol_dsss"}, 32'(bus.sol_dsss), 32'd0);
      chk({tag, "_sol_rlss"}, 32'(bus.sol_rlss), 32'd0);
      chk({tag, "_cnt"}, 32'(bus.cand_cnt), 32'd0);
   endtask

   initial begin
      //           pv     nv             cen   code  hit            rep   srlss sdsss  cnt  done
      vecs[0] = '{8'h1F, 30'h0,         1'b0, 4'd0, 30'h0,         1'b0, 4'h0, 8'h00, 5'd0, 2};
      vecs[1] = '{8'h00, 30'h0,         1'b0, 4'd0, 30'h0,         1'b1, 4'h0, 8'h00, 5'd1, 4};
      vecs[2] = '{8'h03, 30'h7,         1'b1, 4'd2, 30'h3FFFFFFF,  1'b1, 4'h2, 8'h03, 5'd3, 8};
      vecs[3] = '{8'h0F, 30'h1,         1'b0, 4'd0, 30'h0,         1'b0, 4'h0, 8'h00, 5'd6, 24};
      vecs[4] = '{8'h10, 30'h3,         1'b1, 4'd1, 30'h3FFFFFFF,  1'b1, 4'h1, 8'h10, 5'd2, 6};
      vecs[5] = '{8'h07, 30'h3FFFFFFF,  1'b1, 4'd6, 30'h3FFFFFFF,  1'b1, 4'h6, 8'h07, 5'd6, 15};
      vecs[6] = '{8'h0F, 30'h155,       1'b0, 4'd0, 30'h3FFFFFFF,  1'b1, 4'h3, 8'h0F, 5'd1, 7};
      vecs[7] = '{8'h81, 30'h7,         1'b0, 4'd0, 30'h3,         1'b0, 4'h0, 8'h00, 5'd4, 22};

      bus.start          = 1'b0;
      bus.pivot_valid    = 8'h0;
      bus.nonpivot_valid = 30'h0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("reset");

      for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

      // Abort: reset lands in cycle 5 of a four-pivot run.
      @(negedge clk);
      bus.pivot_valid    = 8'h0F;
      bus.nonpivot_valid = 30'h1;
      cov_en = 1'b0;
      cov_hit = 30'h0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("abort");
      begin
         int seen = 0;
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) seen++;
         end
         chk("abort_no_done", 32'(seen), 32'd0);
      end

      // Start pulses mid-run and in the DONE cycle must be ignored.
      run_vec(vecs[2], 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
